// File: rtl/dpr_sync_arbiter.sv
// Two-requester front end for a dpr_sync RAM (one write port, one registered read port).
// Optional macro ARB_COLLISION_FWD_EN: same-address read/write both granted, read data forwarded from the write.
module dpr_sync_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic              mem_blk_select,
    output logic [ADDR_W-1:0] mem_addr_wr,
    output logic [ADDR_W-1:0] mem_addr_rd,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

`ifdef ARB_COLLISION_FWD_EN
    localparam logic FWD_EN = 1'b1;
`else
    localparam logic FWD_EN = 1'b0;
`endif

    logic              rr_ptr_r;       // 1'b0 = A has priority, 1'b1 = B
    logic              wr_go_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;
    logic              rd_acc_s;
    logic              rd_id_s;        // 1'b1 = read belongs to B
    logic [ADDR_W-1:0] rd_addr_s;
    logic              rd_fwd_s;
    logic              rd_mem_s;
    logic              rr_upd_s;

    logic              rd_v1_r, rd_v2_r;
    logic              rd_id1_r, rd_id2_r;
    logic              fwd1_r, fwd2_r;
    logic [DATA_W-1:0] fwd_data1_r, fwd_data2_r;
    logic [DATA_W-1:0] ret_data_s;

    // Grant decision: round-robin for same-type conflicts, write wins a same-address collision
    always_comb begin
        a_gnt    = 1'b0;
        b_gnt    = 1'b0;
        rr_upd_s = 1'b0;
        if (a_req && b_req) begin
            if (a_we != b_we) begin
                if ((a_addr == b_addr) && !FWD_EN) begin
                    a_gnt = a_we;
                    b_gnt = b_we;
                end else begin
                    a_gnt = 1'b1;
                    b_gnt = 1'b1;
                end
            end else begin
                a_gnt    = ~rr_ptr_r;
                b_gnt    = rr_ptr_r;
                rr_upd_s = 1'b1;
            end
        end else begin
            a_gnt = a_req;
            b_gnt = b_req;
        end
    end

    // Steer the accepted write and read onto their RAM ports
    always_comb begin
        wr_go_s   = (a_gnt && a_we) || (b_gnt && b_we);
        wr_addr_s = (a_gnt && a_we) ? a_addr : b_addr;
        wr_data_s = (a_gnt && a_we) ? a_wdata : b_wdata;
        rd_acc_s  = (a_gnt && !a_we) || (b_gnt && !b_we);
        rd_id_s   = !(a_gnt && !a_we);
        rd_addr_s = rd_id_s ? b_addr : a_addr;
        rd_fwd_s  = FWD_EN && rd_acc_s && wr_go_s && (wr_addr_s == rd_addr_s);
        rd_mem_s  = rd_acc_s && !rd_fwd_s;
    end

    // Round-robin pointer moves to the loser of a same-type conflict
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_r <= 1'b0;
        end else if (rr_upd_s) begin
            rr_ptr_r <= a_gnt;
        end
    end

    // RAM port registers: enables pulse one cycle, addresses and data hold when idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wr_en      <= 1'b0;
            mem_rd_en      <= 1'b0;
            mem_blk_select <= 1'b0;
            mem_addr_wr    <= {ADDR_W{1'b0}};
            mem_addr_rd    <= {ADDR_W{1'b0}};
            mem_din        <= {DATA_W{1'b0}};
        end else begin
            mem_wr_en      <= wr_go_s;
            mem_rd_en      <= rd_mem_s;
            mem_blk_select <= wr_go_s || rd_mem_s;
            if (wr_go_s) begin
                mem_addr_wr <= wr_addr_s;
                mem_din     <= wr_data_s;
            end
            if (rd_mem_s) begin
                mem_addr_rd <= rd_addr_s;
            end
        end
    end

    // Read tag pipeline tracks owner and forwarded data alongside the RAM read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_v1_r     <= 1'b0;
            rd_v2_r     <= 1'b0;
            rd_id1_r    <= 1'b0;
            rd_id2_r    <= 1'b0;
            fwd1_r      <= 1'b0;
            fwd2_r      <= 1'b0;
            fwd_data1_r <= {DATA_W{1'b0}};
            fwd_data2_r <= {DATA_W{1'b0}};
        end else begin
            rd_v1_r  <= rd_acc_s;
            rd_id1_r <= rd_id_s;
            fwd1_r   <= rd_fwd_s;
            if (rd_fwd_s) begin
                fwd_data1_r <= wr_data_s;
            end
            rd_v2_r     <= rd_v1_r;
            rd_id2_r    <= rd_id1_r;
            fwd2_r      <= fwd1_r;
            fwd_data2_r <= fwd_data1_r;
        end
    end

    assign ret_data_s = fwd2_r ? fwd_data2_r : mem_dout;

    // Return stage: RAM output is valid two edges after accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= {DATA_W{1'b0}};
            b_rdata  <= {DATA_W{1'b0}};
        end else begin
            a_rvalid <= rd_v2_r && !rd_id2_r;
            b_rvalid <= rd_v2_r && rd_id2_r;
            if (rd_v2_r && !rd_id2_r) begin
                a_rdata <= ret_data_s;
            end
            if (rd_v2_r && rd_id2_r) begin
                b_rdata <= ret_data_s;
            end
        end
    end

endmodule
